// File: rtl/cam_pwr_pkg.sv
// Shared definitions for the camera power sequencer.
//   state_t   : FSM state encoding
//   out_t     : registered sensor-control output bundle (fault and busy kept separately)
//   OUT_OFF   : output values in OFF and reset (rails off, PWDN asserted, sensor in reset)
//   max4()    : elaboration helper used to size the shared down-counter
package cam_pwr_pkg;

    typedef enum logic [3:0] {
        ST_OFF       = 4'd0,
        ST_PU_DOVDD  = 4'd1,
        ST_PU_AVDD   = 4'd2,
        ST_PU_DVDD   = 4'd3,
        ST_PU_MCLK   = 4'd4,
        ST_PU_PWDN   = 4'd5,
        ST_PU_RST    = 4'd6,
        ST_READY     = 4'd7,
        ST_PD_ASSERT = 4'd8,
        ST_PD_MCLK   = 4'd9,
        ST_PD_DVDD   = 4'd10,
        ST_PD_AVDD   = 4'd11,
        ST_PD_DOVDD  = 4'd12,
        ST_FAULT     = 4'd13
    } state_t;

    typedef struct packed {
        logic dovdd;
        logic avdd;
        logic dvdd;
        logic mclk;
        logic pwdn;
        logic rst_n;
        logic ready;
    } out_t;

    // dovdd avdd dvdd mclk pwdn rst_n ready
    localparam out_t OUT_OFF = 7'b000_0100;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/cam_seq_timer.sv
// Loadable down-counter shared by all sequencer wait states.
//   clk, rst_n : clock, async active-low reset
//   load       : load value on the next edge (takes priority over counting)
//   value      : load value (state duration minus one)
//   done       : counter has reached zero
module cam_seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/cam_power_seq.sv
// Camera-sensor power/clock sequencer.
// Brings up DOVDD -> AVDD -> DVDD -> MCLK -> PWDN release -> reset release -> ready with
// programmable gaps, and tears down in reverse order when en drops.
// Ports:
//   clk, rst_n                : clock, async active-low reset
//   en                        : 1 = power up, 0 = power down
//   pg_dovdd/pg_avdd/pg_dvdd  : rail power-good inputs (only with CAM_PGOOD_CHECK_EN)
//   dovdd_en/avdd_en/dvdd_en  : rail enables
//   mclk_en                   : MCLK gate
//   cam_pwdn, cam_rst_n       : sensor power-down / reset pins
//   ready, busy, fault        : status
// Optional feature macro: CAM_PGOOD_CHECK_EN (power-good supervision and FAULT state).
//
// state        | meaning
// OFF          | everything off, waiting for en=1
// PU_DOVDD     | I/O rail on, wait T_STEP
// PU_AVDD      | analog rail on, wait T_STEP
// PU_DVDD      | core rail on, wait T_STEP
// PU_MCLK      | MCLK running, wait T_MCLK
// PU_PWDN      | PWDN released, wait T_RST
// PU_RST       | reset released, wait T_SETTLE
// READY        | sensor usable
// PD_ASSERT    | PWDN/reset asserted, ready dropped (1 cycle)
// PD_MCLK      | MCLK stopped (T_STEP if it was running, else 1 cycle)
// PD_DVDD      | core rail off (same rule)
// PD_AVDD      | analog rail off (same rule)
// PD_DOVDD     | I/O rail off (same rule)
// FAULT        | power-good lost, outputs off, wait for en=0
module cam_power_seq
    import cam_pwr_pkg::*;
#(
    parameter int T_STEP_CYC   = 50_000,
    parameter int T_MCLK_CYC   = 50_000,
    parameter int T_RST_CYC    = 50_000,
    parameter int T_SETTLE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
`ifdef CAM_PGOOD_CHECK_EN
    input  logic pg_dovdd,
    input  logic pg_avdd,
    input  logic pg_dvdd,
`endif
    output logic dovdd_en,
    output logic avdd_en,
    output logic dvdd_en,
    output logic mclk_en,
    output logic cam_pwdn,
    output logic cam_rst_n,
    output logic ready,
    output logic busy,
    output logic fault
);

    localparam int T_MAX = max4(T_STEP_CYC, T_MCLK_CYC, T_RST_CYC, T_SETTLE_CYC);
    localparam int CW    = $clog2(T_MAX) + 1;

    localparam logic [CW-1:0] L_STEP   = CW'(T_STEP_CYC - 1);
    localparam logic [CW-1:0] L_MCLK   = CW'(T_MCLK_CYC - 1);
    localparam logic [CW-1:0] L_RST    = CW'(T_RST_CYC - 1);
    localparam logic [CW-1:0] L_SETTLE = CW'(T_SETTLE_CYC - 1);

    state_t          state_q, state_d;
    out_t            out_q;
    logic            busy_q;
    logic            tmr_load;
    logic [CW-1:0]   tmr_value;
    logic            tmr_done;
    logic            ok_dovdd, ok_avdd, ok_dvdd, pg_lost;

`ifdef CAM_PGOOD_CHECK_EN
    logic [2:0] pg_meta_q, pg_sync_q;
    logic       fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pg_meta_q <= 3'b000;
            pg_sync_q <= 3'b000;
        end else begin
            pg_meta_q <= {pg_dovdd, pg_avdd, pg_dvdd};
            pg_sync_q <= pg_meta_q;
        end
    end

    assign ok_dovdd = pg_sync_q[2];
    assign ok_avdd  = pg_sync_q[1];
    assign ok_dvdd  = pg_sync_q[0];
    assign pg_lost  = ~&pg_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault_q <= 1'b0;
        else        fault_q <= (state_q == ST_FAULT);
    end

    assign fault = fault_q;
`else
    assign ok_dovdd = 1'b1;
    assign ok_avdd  = 1'b1;
    assign ok_dvdd  = 1'b1;
    assign pg_lost  = 1'b0;
    assign fault    = 1'b0;
`endif

    cam_seq_timer #(.W(CW)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .value (tmr_value),
        .done  (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_OFF;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:       if (en) state_d = ST_PU_DOVDD;
            ST_PU_DOVDD:  if (!en) state_d = ST_PD_ASSERT;
                          else if (tmr_done) state_d = ok_dovdd ? ST_PU_AVDD : ST_FAULT;
            ST_PU_AVDD:   if (!en) state_d = ST_PD_ASSERT;
                          else if (tmr_done) state_d = ok_avdd ? ST_PU_DVDD : ST_FAULT;
            ST_PU_DVDD:   if (!en) state_d = ST_PD_ASSERT;
                          else if (tmr_done) state_d = ok_dvdd ? ST_PU_MCLK : ST_FAULT;
            ST_PU_MCLK:   if (pg_lost) state_d = ST_FAULT;
                          else if (!en) state_d = ST_PD_ASSERT;
                          else if (tmr_done) state_d = ST_PU_PWDN;
            ST_PU_PWDN:   if (pg_lost) state_d = ST_FAULT;
                          else if (!en) state_d = ST_PD_ASSERT;
                          else if (tmr_done) state_d = ST_PU_RST;
            ST_PU_RST:    if (pg_lost) state_d = ST_FAULT;
                          else if (!en) state_d = ST_PD_ASSERT;
                          else if (tmr_done) state_d = ST_READY;
            ST_READY:     if (pg_lost) state_d = ST_FAULT;
                          else if (!en) state_d = ST_PD_ASSERT;
            ST_PD_ASSERT: state_d = ST_PD_MCLK;
            ST_PD_MCLK:   if (tmr_done) state_d = ST_PD_DVDD;
            ST_PD_DVDD:   if (tmr_done) state_d = ST_PD_AVDD;
            ST_PD_AVDD:   if (tmr_done) state_d = ST_PD_DOVDD;
            ST_PD_DOVDD:  if (tmr_done) state_d = ST_OFF;
            ST_FAULT:     if (!en) state_d = ST_OFF;
            default:      state_d = ST_OFF;
        endcase

        // Duration is fixed on entry. Power-down steps look at the registered output,
        // which the previous state never touches, so it reflects the signal on entry.
        tmr_load  = (state_d != state_q);
        tmr_value = '0;
        case (state_d)
            ST_PU_DOVDD, ST_PU_AVDD, ST_PU_DVDD: tmr_value = L_STEP;
            ST_PU_MCLK:  tmr_value = L_MCLK;
            ST_PU_PWDN:  tmr_value = L_RST;
            ST_PU_RST:   tmr_value = L_SETTLE;
            ST_PD_MCLK:  tmr_value = out_q.mclk  ? L_STEP : '0;
            ST_PD_DVDD:  tmr_value = out_q.dvdd  ? L_STEP : '0;
            ST_PD_AVDD:  tmr_value = out_q.avdd  ? L_STEP : '0;
            ST_PD_DOVDD: tmr_value = out_q.dovdd ? L_STEP : '0;
            default:     tmr_value = '0;
        endcase
    end

    // Outputs are registered from the current state; each step only touches its own bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= OUT_OFF;
            busy_q <= 1'b0;
        end else begin
            busy_q <= !(state_q inside {ST_OFF, ST_READY, ST_FAULT});
            case (state_q)
                ST_OFF, ST_FAULT: out_q <= OUT_OFF;
                ST_PU_DOVDD:  out_q.dovdd <= 1'b1;
                ST_PU_AVDD:   out_q.avdd  <= 1'b1;
                ST_PU_DVDD:   out_q.dvdd  <= 1'b1;
                ST_PU_MCLK:   out_q.mclk  <= 1'b1;
                ST_PU_PWDN:   out_q.pwdn  <= 1'b0;
                ST_PU_RST:    out_q.rst_n <= 1'b1;
                ST_READY:     out_q.ready <= 1'b1;
                ST_PD_ASSERT: begin
                    out_q.pwdn  <= 1'b1;
                    out_q.rst_n <= 1'b0;
                    out_q.ready <= 1'b0;
                end
                ST_PD_MCLK:   out_q.mclk  <= 1'b0;
                ST_PD_DVDD:   out_q.dvdd  <= 1'b0;
                ST_PD_AVDD:   out_q.avdd  <= 1'b0;
                ST_PD_DOVDD:  out_q.dovdd <= 1'b0;
                default:      out_q <= OUT_OFF;
            endcase
        end
    end

    assign dovdd_en  = out_q.dovdd;
    assign avdd_en   = out_q.avdd;
    assign dvdd_en   = out_q.dvdd;
    assign mclk_en   = out_q.mclk;
    assign cam_pwdn  = out_q.pwdn;
    assign cam_rst_n = out_q.rst_n;
    assign ready     = out_q.ready;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cam_power_seq.sv
// Directed bench for cam_power_seq with short timing parameters
// (T_STEP=4, T_MCLK=2, T_RST=3, T_SETTLE=5). Output vector checked as
// {dovdd, avdd, dvdd, mclk, pwdn, rst_n, ready, busy}.
module tb_cam_power_seq;

    logic clk;
    logic rst_n;
    logic en;
    logic pg_dovdd, pg_avdd, pg_dvdd;
    logic dovdd_en, avdd_en, dvdd_en, mclk_en, cam_pwdn, cam_rst_n, ready, busy, fault;

    int n_tests = 0;
    int n_fail  = 0;

    cam_power_seq #(
        .T_STEP_CYC   (4),
        .T_MCLK_CYC   (2),
        .T_RST_CYC    (3),
        .T_SETTLE_CYC (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
`ifdef CAM_PGOOD_CHECK_EN
        .pg_dovdd  (pg_dovdd),
        .pg_avdd   (pg_avdd),
        .pg_dvdd   (pg_dvdd),
`endif
        .dovdd_en  (dovdd_en),
        .avdd_en   (avdd_en),
        .dvdd_en   (dvdd_en),
        .mclk_en   (mclk_en),
        .cam_pwdn  (cam_pwdn),
        .cam_rst_n (cam_rst_n),
        .ready     (ready),
        .busy      (busy),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {dovdd_en, avdd_en, dvdd_en, mclk_en, cam_pwdn, cam_rst_n, ready, busy};
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_fault(input string tag, input logic exp);
        n_tests++;
        assert (fault === exp) else begin
            n_fail++;
            $error("FAIL %s: observed fault=%b expected fault=%b", tag, fault, exp);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        pg_dovdd = 1'b1;
        pg_avdd  = 1'b1;
        pg_dvdd  = 1'b1;

        #12;
        chk("reset_outputs", 8'b0000_1000);
        chk_fault("reset_fault", 1'b0);

        // 1: power-up from reset release; first en-high edge is E0
        step(1);
        rst_n = 1'b1;
        en    = 1'b1;
        step(1);  chk("pu_e0_still_off", 8'b0000_1000);
        step(1);  chk("pu_dovdd_e1",     8'b1000_1001);
        step(3);  chk("pu_dovdd_e4",     8'b1000_1001);
        step(1);  chk("pu_avdd_e5",      8'b1100_1001);
        step(4);  chk("pu_dvdd_e9",      8'b1110_1001);
        step(4);  chk("pu_mclk_e13",     8'b1111_1001);
        step(2);  chk("pu_pwdn_e15",     8'b1111_0001);
        step(3);  chk("pu_rst_e18",      8'b1111_0101);
        step(4);  chk("pu_settle_e22",   8'b1111_0101);
        step(1);  chk("pu_ready_e23",    8'b1111_0110);

        // 2: power-down from READY; 4: en raised mid power-down is ignored
        en = 1'b0;
        step(1);  chk("pd_n0",           8'b1111_0110);
        step(1);  chk("pd_assert_n1",    8'b1111_1001);
        step(1);  chk("pd_mclk_n2",      8'b1110_1001);
        step(4);  chk("pd_dvdd_n6",      8'b1100_1001);
        step(4);  chk("pd_avdd_n10",     8'b1000_1001);
        en = 1'b1;
        step(4);  chk("pd_dovdd_n14",    8'b0000_1001);
        step(3);  chk("pd_busy_n17",     8'b0000_1001);
        step(1);  chk("pd_off_n18",      8'b0000_1000);
        step(1);  chk("restart_dovdd",   8'b1000_1001);

        // 3: abort during PU_AVDD; empty steps take one cycle each
        step(4);  chk("restart_avdd",    8'b1100_1001);
        en = 1'b0;
        step(4);  chk("abort_m3",        8'b1100_1001);
        step(1);  chk("abort_avdd_off",  8'b1000_1001);
        step(3);  chk("abort_m7",        8'b1000_1001);
        step(1);  chk("abort_dovdd_off", 8'b0000_1001);
        step(3);  chk("abort_m11",       8'b0000_1001);
        step(1);  chk("abort_off",       8'b0000_1000);
        step(3);  chk("off_idle",        8'b0000_1000);

        // 6: async reset in READY
        en = 1'b1;
        step(24); chk("ready_again",     8'b1111_0110);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset",               8'b0000_1000);
        en = 1'b0;
        #2;
        rst_n = 1'b1;
        step(2);  chk("after_reset_off", 8'b0000_1000);

`ifdef CAM_PGOOD_CHECK_EN
        // 5: AVDD power-good missing at expiry
        pg_avdd = 1'b0;
        en      = 1'b1;
        step(9);  chk("pg_avdd_e8",      8'b1100_1001);
        chk_fault("pg_avdd_e8_fault", 1'b0);
        step(1);  chk("pg_fault_outs",   8'b0000_1000);
        chk_fault("pg_fault_set", 1'b1);
        en = 1'b0;
        step(1);  chk_fault("pg_fault_held", 1'b1);
        step(1);  chk_fault("pg_fault_clr",  1'b0);
        chk("pg_off",                    8'b0000_1000);

        // DVDD power-good lost in READY
        pg_avdd = 1'b1;
        en      = 1'b1;
        step(24); chk("pg_ready",        8'b1111_0110);
        pg_dvdd = 1'b0;
        step(3);  chk("pg_drop_e3",      8'b1111_0110);
        step(1);  chk("pg_drop_outs",    8'b0000_1000);
        chk_fault("pg_drop_fault", 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
